// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: circular FIFO of {pc, inst, fault} between fetch and decode.
// The oldest entry is presented combinationally on deq_*; an empty queue shows
// a canonical NOP (addi x0,x0,0) with pc 0 so decode never sees stale data.
// A synchronous flush empties the queue and discards same-cycle handshakes.
// Optional build macro IFQ_BYPASS_EN: when the queue is empty, an incoming
// entry is forwarded to deq_* in the same cycle (zero-latency bypass).
module inst_fetch_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [PC_W-1:0]  enq_pc,
  input  logic [31:0]      enq_inst,
  input  logic             enq_fault,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [PC_W-1:0]  deq_pc,
  output logic [31:0]      deq_inst,
  output logic             deq_fault,
  output logic [PTR_W:0]   count
);

  localparam logic [31:0]    NOP_INST = 32'h0000_0013;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  // Entry storage; contents are don't-care until written.
  logic [PC_W-1:0] mem_pc    [DEPTH];
  logic [31:0]     mem_inst  [DEPTH];
  logic            mem_fault [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic stored_valid;
  logic bypass;
  logic enq_fire;
  logic deq_fire;
  logic wr_en;
  logic pop;

  // Handshake decode: ready/valid come from occupancy, plus the optional bypass.
  always_comb begin
    stored_valid = (count_q != '0);
    enq_ready    = (count_q != FULL_CNT);
`ifdef IFQ_BYPASS_EN
    bypass       = (count_q == '0) && !flush && enq_valid;
`else
    bypass       = 1'b0;
`endif
    deq_valid    = stored_valid | bypass;
    enq_fire     = enq_valid & enq_ready;
    deq_fire     = deq_valid & deq_ready;
    // A bypassed entry consumed in the same cycle never touches storage.
    wr_en        = enq_fire & ~(bypass & deq_ready);
    pop          = deq_fire & ~bypass;
  end

  // Head presentation: stored head, else bypassed entry, else canonical NOP.
  always_comb begin
    deq_pc    = '0;
    deq_inst  = NOP_INST;
    deq_fault = 1'b0;
    if (stored_valid) begin
      deq_pc    = mem_pc[head_q];
      deq_inst  = mem_inst[head_q];
      deq_fault = mem_fault[head_q];
    end else if (bypass) begin
      deq_pc    = enq_pc;
      deq_inst  = enq_inst;
      deq_fault = enq_fault;
    end
  end

  // Pointer and occupancy next-state; flush overrides both handshakes.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) tail_d = tail_q + PTR_W'(1);
      if (pop)   head_d = head_q + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count_d = count_q + (PTR_W + 1)'(1);
        2'b01:   count_d = count_q - (PTR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry write at tail; a flush-cycle enqueue is dropped.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      mem_pc[tail_q]    <= enq_pc;
      mem_inst[tail_q]  <= enq_inst;
      mem_fault[tail_q] <= enq_fault;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios followed by
// random traffic, every cycle compared against a queue-based reference model.
// Build with +define+IFQ_BYPASS_EN to exercise the bypass variant.
module tb_inst_fetch_queue;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;
  localparam int PC_W  = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             enq_valid;
  logic             enq_ready;
  logic [PC_W-1:0]  enq_pc;
  logic [31:0]      enq_inst;
  logic             enq_fault;
  logic             deq_valid;
  logic             deq_ready;
  logic [PC_W-1:0]  deq_pc;
  logic [31:0]      deq_inst;
  logic             deq_fault;
  logic [PTR_W:0]   count;

  inst_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc),
    .enq_inst(enq_inst), .enq_fault(enq_fault),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_pc(deq_pc),
    .deq_inst(deq_inst), .deq_fault(deq_fault), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } ent_t;

  ent_t model_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   last_accept;

`ifdef IFQ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check against the model mid-cycle,
  // then advance the model across the rising edge.
  task automatic cycle(input logic fl, input logic ev, input logic [31:0] pc,
                       input logic [31:0] inst, input logic flt, input logic dr);
    bit   e_ready, e_valid, byp, enq_ok, deq_ok;
    ent_t head;
    flush = fl; enq_valid = ev; enq_pc = pc; enq_inst = inst;
    enq_fault = flt; deq_ready = dr;
    @(negedge clk);
    e_ready = (model_q.size() != DEPTH);
    byp     = BYPASS && (model_q.size() == 0) && !fl && ev;
    e_valid = (model_q.size() != 0) || byp;
    if (model_q.size() != 0) head = model_q[0];
    else if (byp)            head = '{pc: pc, inst: inst, fault: flt};
    else                     head = '{pc: 32'h0, inst: 32'h13, fault: 1'b0};
    check("enq_ready", 64'(enq_ready), 64'(e_ready));
    check("deq_valid", 64'(deq_valid), 64'(e_valid));
    check("count",     64'(count),     64'(model_q.size()));
    check("deq_pc",    64'(deq_pc),    64'(head.pc));
    check("deq_inst",  64'(deq_inst),  64'(head.inst));
    check("deq_fault", 64'(deq_fault), 64'(head.fault));
    enq_ok = ev && e_ready && !fl;
    deq_ok = e_valid && dr && !fl;
    if (deq_ok)
      $display("deq pc=%08h inst=%08h fault=%0d count=%0d", head.pc, head.inst, head.fault, model_q.size());
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else if (!(byp && dr)) begin
      if (deq_ok) void'(model_q.pop_front());
      if (enq_ok) model_q.push_back('{pc: pc, inst: inst, fault: flt});
    end
    last_accept = enq_ok;
    #1;
  endtask

  task automatic idle(input logic dr);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, dr);
  endtask

  initial begin
    logic [31:0] fpc;
    logic [31:0] finst;
    logic        ffault;
    rst_n = 1'b0; flush = 1'b0; enq_valid = 1'b0; enq_pc = '0;
    enq_inst = '0; enq_fault = 1'b0; deq_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_deq_valid", 64'(deq_valid), 64'd0);
    check("rst_deq_inst",  64'(deq_inst),  64'h13);
    check("rst_enq_ready", 64'(enq_ready), 64'd1);
    check("rst_count",     64'(count),     64'd0);
    rst_n = 1'b1;
    idle(1'b0);
    idle(1'b1);

    // Fill to full, attempt a ninth entry, then drain in order.
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b0, 1'b1, 32'(i * 4), 32'h1000 + 32'(i), 1'b0, 1'b0);
    check("full_count", 64'(count), 64'd8);
    check("full_enq_ready", 64'(enq_ready), 64'd0);
    cycle(1'b0, 1'b1, 32'h20, 32'h2000, 1'b0, 1'b0);
    check("ninth_rejected", 64'(count), 64'd8);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_order_pc", 64'(deq_pc), 64'(i * 4));
      idle(1'b1);
    end

    // Streaming: simultaneous enq/deq across the pointer wrap.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, 32'h200 + 32'(i * 4), 32'h3000 + 32'(i), 1'b0, 1'b1);
      if (i > 0 && !BYPASS) check("stream_count", 64'(count), 64'd1);
    end
    idle(1'b1);

    // Flush with five entries while both handshakes are asserted.
    for (int i = 0; i < 5; i++)
      cycle(1'b0, 1'b1, 32'h300 + 32'(i * 4), 32'h4000, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h400, 32'h5000, 1'b0, 1'b1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_deq_valid", 64'(deq_valid), 64'd0);
    idle(1'b0);

    // Fault propagation.
    cycle(1'b0, 1'b1, 32'h100, 32'h33, 1'b1, 1'b0);
    check("fault_flag", 64'(deq_fault), 64'd1);
    check("fault_pc",   64'(deq_pc),    64'h100);
    idle(1'b0);
    idle(1'b1);

    // Empty-queue enqueue with deq_ready: bypass vs one-cycle latency.
    flush = 1'b0; enq_valid = 1'b1; enq_pc = 32'h40; enq_inst = 32'h13;
    enq_fault = 1'b0; deq_ready = 1'b1;
    #1;
    check("bypass_same_cycle_valid", 64'(deq_valid), 64'(BYPASS));
    cycle(1'b0, 1'b1, 32'h40, 32'h13, 1'b0, 1'b1);
    check("bypass_next_count", 64'(count), BYPASS ? 64'd0 : 64'd1);
    idle(1'b1);

    // Random traffic with a fetch unit that holds until accepted.
    fpc = 32'h8000; finst = $urandom; ffault = 1'($urandom_range(0, 15) == 0);
    for (int i = 0; i < 500; i++) begin
      logic fl, ev, dr;
      fl = ($urandom_range(0, 39) == 0);
      ev = ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 2) != 0);
      cycle(fl, ev, fpc, finst, ffault, dr);
      if (fl) begin
        fpc = {$urandom_range(0, 255), 2'b00} + 32'h9000;
        finst = $urandom; ffault = 1'($urandom_range(0, 15) == 0);
      end else if (last_accept) begin
        fpc += 4; finst = $urandom; ffault = 1'($urandom_range(0, 15) == 0);
      end
    end

    // Asynchronous reset in the middle of a cycle with entries queued.
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b1, 32'h500 + 32'(i * 4), 32'h77, 1'b1, 1'b0);
    flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_count", 64'(count),     64'd0);
    check("async_rst_valid", 64'(deq_valid), 64'd0);
    check("async_rst_inst",  64'(deq_inst),  64'h13);
    check("async_rst_fault", 64'(deq_fault), 64'd0);
    model_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1'b1);
    cycle(1'b0, 1'b1, 32'h600, 32'h88, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached before end of test");
    $fatal(1, "timeout");
  end

endmodule
